matmul_compute: RTL
===================

# matmul_compute

Compute stage directly downstream of the input matrix memories. Once both matrices are loaded, it reads A (M×K) and B (K×N) through the memories' read ports and forms C = A·B with one signed multiply-accumulate per cycle. It streams C out row-major over an AXI-Stream master, then pulses `compute_finished` so upstream can accept the next matrix pair.

## Interface
- `INW`, default 12: signed element width of A and B.
- `M`, default 7: rows of A and C.
- `N`, default 9: columns of B and C.
- `MAXK`, default 8: maximum shared dimension K.
- `OUTW`, default 2*INW+$clog2(MAXK): signed width of C elements; sized so accumulation cannot overflow.
- `K_BITS` (local) = $clog2(MAXK+1); `A_ADDR_BITS` (local) = $clog2(M*MAXK); `B_ADDR_BITS` (local) = $clog2(MAXK*N).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `matrices_loaded`  in  1  A and B are valid in memory; held high by upstream until `compute_finished`.
- `K`  in  K_BITS  shared dimension; valid while `matrices_loaded` is high.
- `A_read_addr`  out  A_ADDR_BITS  A memory read address.
- `A_data`  in  INW  signed; A memory data, one cycle after the address.
- `B_read_addr`  out  B_ADDR_BITS  B memory read address.
- `B_data`  in  INW  signed; B memory data, one cycle after the address.
- `compute_finished`  out  1  one-cycle pulse after the last C element is accepted.
- `AXIS_TDATA`  out  OUTW  signed C element.
- `AXIS_TVALID`  out  1  `AXIS_TDATA` is valid.
- `AXIS_TREADY`  in  1  downstream accepts the element.

## Operation
- Address map:
  - A[i][k] is at address i*K+k.
  - B[k][j] is at address k*N+j.
  - Address arithmetic is unsigned and truncated to the address width.
- FSM states: IDLE, ACCUM, OUTPUT, DONE.
- IDLE:
  - On `matrices_loaded`=1, latch `K` into `k_reg`, clear i, j, k and the accumulator, then go to ACCUM.
- ACCUM:
  - For k = 0..k_reg-1, issue one A and one B address per cycle.
  - Each product `A_data*B_data` (signed, 2*INW bits, sign-extended to OUTW) is added to the accumulator in the cycle its data returns.
  - After the final product is added, go to OUTPUT.
- OUTPUT:
  - `AXIS_TVALID`=1 with `AXIS_TDATA` = accumulator.
  - Data is held stable until `AXIS_TVALID`&`AXIS_TREADY`.
  - On handshake: clear the accumulator and advance j (wrapping to 0 and incrementing i at N-1).
  - Go to ACCUM, or to DONE after element (M-1, N-1).
- DONE:
  - Assert `compute_finished` for exactly one cycle, then go to IDLE.
- K=0:
  - ACCUM is skipped; every C element is 0.
  - All M*N zeros are still streamed.
- `matrices_loaded` is ignored outside IDLE; `K` is sampled only on IDLE exit.
- Reset, including mid-computation:
  - Next cycle is IDLE.
  - `AXIS_TVALID`=0, `compute_finished`=0, `AXIS_TDATA`=0, both addresses=0.
  - Accumulator and counters are cleared; a partially streamed matrix is abandoned.

## Timing
- Memory read latency is one cycle.
- Per element (K≥1): addresses are issued in cycles 0..K-1 of ACCUM, the last product is accumulated at the end of cycle K, and `AXIS_TVALID` rises in cycle K+1.
- With `MATMUL_PIPE_MULT_EN`, every latency figure gains one cycle.
- No overlap between elements: the next element's first address is issued the cycle after the handshake.
- Element period is K+2 cycles under full TREADY (K+3 with the pipeline option); K=0 gives 1 cycle per element.
- First `compute_finished` occurs one cycle after the final handshake.
- Earliest next IDLE exit is two cycles after the final handshake.

## Configuration
- `MATMUL_PIPE_MULT_EN`:
  - Defined: the product is registered before the adder, for timing closure; ACCUM lasts one extra cycle per element.
  - Undefined: the multiply and add are combinational in one cycle.
- Results are identical either way; only latency changes.

## Structure
- Shared package `matmul_pkg`:
  - FSM state enum.
  - Width helper functions/localparams (K_BITS, address widths, default OUTW), shared with the input memory stage.
- Sub-module `mac_unit`:
  - Inputs: signed a and b, `clear`, `en`.
  - Output: OUTW accumulator.
  - Holds the optional product register controlled by `MATMUL_PIPE_MULT_EN`.
- Counters, address generation, FSM and the AXIS interface live in the top.

## Test plan
- M=2, N=2, K=2; A=[[1,2],[3,4]], B=[[5,6],[7,8]]; TREADY=1 → TDATA 19,22,43,50 in order, then one `compute_finished` pulse.
- Signed extremes, INW=12, K=8: all A=-2048, all B=-2048 → every element = 33554432, no overflow.
- K=0 with `matrices_loaded` → M*N zeros streamed, then `compute_finished`.
- Random TREADY backpressure (about 50% low) → TDATA held stable while TVALID && !TREADY; sequence matches the golden model.
- Reset asserted mid-OUTPUT → next cycle TVALID=0, FSM in IDLE; a fresh run after reset produces correct results.
- Build with and without `MATMUL_PIPE_MULT_EN` on the same stimulus → identical outputs; element period differs by exactly 1 cycle.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply datapath and its input memory stage.
package matmul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StOutput,
        StDone
    } state_t;

    localparam int DefaultInw  = 12;
    localparam int DefaultMaxk = 8;

    function automatic int k_bits(input int maxk);
        return $clog2(maxk + 1);
    endfunction

    function automatic int addr_bits(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

    // Wide enough that MAXK full-scale products cannot overflow.
    function automatic int default_outw(input int inw, input int maxk);
        return 2 * inw + $clog2(maxk);
    endfunction

endpackage

// File: rtl/matmul_compute_mac_unit.sv
// Signed multiply-accumulate; MATMUL_PIPE_MULT_EN inserts a product register before the adder.
module mac_unit
    import matmul_pkg::*;
#(
    parameter int INW  = DefaultInw,
    parameter int OUTW = default_outw(DefaultInw, DefaultMaxk)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic signed [INW-1:0]  a,
    input  logic signed [INW-1:0]  b,
    input  logic                   clear,
    input  logic                   en,
    output logic signed [OUTW-1:0] acc
);

    logic signed [2*INW-1:0] prod;
    assign prod = a * b;

`ifdef MATMUL_PIPE_MULT_EN
    logic signed [2*INW-1:0] prod_q;
    logic                    prod_valid_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            acc          <= '0;
        end else begin
            prod_valid_q <= en;
            if (en) begin
                prod_q <= prod;
            end
            if (prod_valid_q) begin
                acc <= acc + OUTW'(prod_q);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + OUTW'(prod);
        end
    end
`endif

endmodule

// File: rtl/matmul_compute.sv
// C = A*B compute stage: address generation, FSM and AXI-Stream output.
// Optional MATMUL_PIPE_MULT_EN adds one cycle of multiply latency per element.
module matmul_compute
    import matmul_pkg::*;
#(
    parameter int INW  = DefaultInw,
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = DefaultMaxk,
    parameter int OUTW = default_outw(INW, MAXK),
    localparam int K_BITS      = k_bits(MAXK),
    localparam int A_ADDR_BITS = addr_bits(M, MAXK),
    localparam int B_ADDR_BITS = addr_bits(MAXK, N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   matrices_loaded,
    input  logic [K_BITS-1:0]      K,
    output logic [A_ADDR_BITS-1:0] A_read_addr,
    input  logic signed [INW-1:0]  A_data,
    output logic [B_ADDR_BITS-1:0] B_read_addr,
    input  logic signed [INW-1:0]  B_data,
    output logic                   compute_finished,
    output logic signed [OUTW-1:0] AXIS_TDATA,
    output logic                   AXIS_TVALID,
    input  logic                   AXIS_TREADY
);

    localparam int I_BITS = $clog2(M + 1);
    localparam int J_BITS = $clog2(N + 1);
    localparam logic [I_BITS-1:0] ILast = I_BITS'(M - 1);
    localparam logic [J_BITS-1:0] JLast = J_BITS'(N - 1);

    state_t                 state_q;
    logic [K_BITS-1:0]      k_reg_q;
    logic [K_BITS-1:0]      k_cnt_q;
    logic [I_BITS-1:0]      i_q, i_nxt;
    logic [J_BITS-1:0]      j_q, j_nxt;
    logic [A_ADDR_BITS-1:0] a_addr_q, a_base_nxt;
    logic [B_ADDR_BITS-1:0] b_addr_q;
    logic                   rd_valid_q;
    logic                   tvalid_q;
    logic                   finished_q;
    logic                   mac_clear;
    logic                   last_prod;

    assign A_read_addr      = a_addr_q;
    assign B_read_addr      = b_addr_q;
    assign AXIS_TVALID      = tvalid_q;
    assign compute_finished = finished_q;

    assign mac_clear = (state_q == StIdle && matrices_loaded) ||
                       (state_q == StOutput && AXIS_TREADY);

    always_comb begin
        i_nxt = i_q;
        j_nxt = j_q + J_BITS'(1);
        if (j_q == JLast) begin
            j_nxt = '0;
            i_nxt = i_q + I_BITS'(1);
        end
    end

    assign a_base_nxt = A_ADDR_BITS'(32'(i_nxt) * 32'(k_reg_q));

`ifdef MATMUL_PIPE_MULT_EN
    logic pipe_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_q <= 1'b0;
        end else begin
            pipe_valid_q <= rd_valid_q;
        end
    end

    // Last product sits in the product register with no read still in flight.
    assign last_prod = pipe_valid_q && !rd_valid_q;
`else
    assign last_prod = rd_valid_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            k_reg_q    <= '0;
            k_cnt_q    <= '0;
            i_q        <= '0;
            j_q        <= '0;
            a_addr_q   <= '0;
            b_addr_q   <= '0;
            rd_valid_q <= 1'b0;
            tvalid_q   <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            finished_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (matrices_loaded) begin
                        k_reg_q  <= K;
                        k_cnt_q  <= '0;
                        i_q      <= '0;
                        j_q      <= '0;
                        a_addr_q <= '0;
                        b_addr_q <= '0;
                        if (K == '0) begin
                            state_q  <= StOutput;
                            tvalid_q <= 1'b1;
                        end else begin
                            state_q <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (k_cnt_q < k_reg_q) begin
                        rd_valid_q <= 1'b1;
                        k_cnt_q    <= k_cnt_q + K_BITS'(1);
                        if (k_cnt_q + K_BITS'(1) < k_reg_q) begin
                            a_addr_q <= a_addr_q + A_ADDR_BITS'(1);
                            b_addr_q <= b_addr_q + B_ADDR_BITS'(N);
                        end
                    end else if (last_prod) begin
                        state_q  <= StOutput;
                        tvalid_q <= 1'b1;
                    end
                end
                StOutput: begin
                    if (AXIS_TREADY) begin
                        if (i_q == ILast && j_q == JLast) begin
                            state_q    <= StDone;
                            tvalid_q   <= 1'b0;
                            finished_q <= 1'b1;
                        end else begin
                            i_q      <= i_nxt;
                            j_q      <= j_nxt;
                            k_cnt_q  <= '0;
                            a_addr_q <= a_base_nxt;
                            b_addr_q <= B_ADDR_BITS'(j_nxt);
                            // With K=0 every element is an immediate zero.
                            if (k_reg_q != '0) begin
                                state_q  <= StAccum;
                                tvalid_q <= 1'b0;
                            end
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    mac_unit #(
        .INW  (INW),
        .OUTW (OUTW)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .a     (A_data),
        .b     (B_data),
        .clear (mac_clear),
        .en    (rd_valid_q),
        .acc   (AXIS_TDATA)
    );

endmodule
